fetch_decode_ctl: RTL and testbench
===================================

Name: fetch_decode_ctl

Overview:
Multi-cycle instruction fetch, decode and control stage that sits directly upstream of the register-file/ALU/data-memory datapath.
- Owns the PC and the instruction register (IR).
- Fetches 32-bit MIPS words from an external instruction memory.
- Drives the datapath's register fields, immediate, function code and per-cycle control strobes.
- Resolves beq (using the datapath's Zero) and j.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_INC, 4, byte increment per fetched instruction

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous active-high reset
imem_addr  out  32  fetch address, equal to pc
imem_data  in  32  instruction word, valid when imem_ready=1
imem_ready  in  1  fetch handshake: instruction available this cycle
Zero  in  1  ALU zero flag from datapath
rs  out  5  IR[25:21]
rt  out  5  IR[20:16]
rd  out  5  IR[15:11]
SEin  out  16  IR[15:0], immediate before sign extension
FuncCode  out  4  IR[3:0]
Regsel  out  1  write-register select: 1=rd (R-type), 0=rt
ALUsel  out  1  ALU B select: 1=sign-extended immediate
ALUOp  out  2  00=add, 01=sub, 10=use FuncCode
MemRead  out  1  data-memory read strobe
MemWrite  out  1  data-memory write strobe
MemToRegSel  out  1  write-back select: 1=memory data
RegWrite  out  1  register-file write strobe
pc  out  32  current PC
instr_done  out  1  one-cycle pulse in the last cycle of each instruction
illegal  out  1  sticky: unsupported opcode decoded

Behaviour:
Reset values:
- pc=RESET_PC, IR=0, state=FETCH, illegal=0.
- All strobes and instr_done are 0.
- Strobes are gated low combinationally while reset=1, so no write occurs at the reset edge even if reset arrives mid-instruction in MEM or WB.

States: FETCH, DECODE, EXEC, MEM, WB.

FETCH:
- imem_addr=pc.
- If imem_ready=1: IR<=imem_data, pc<=pc+PC_INC (mod 2^32), go to DECODE.
- Otherwise hold with pc unchanged; the fetch may stall indefinitely.

DECODE, by opcode IR[31:26]:
- j (000010): pc<={pc[31:28],IR[25:0],2'b00}, instr_done=1, go to FETCH.
- Illegal opcode: illegal<=1, instr_done=1, go to FETCH; no strobes asserted.
- Other legal opcodes: go to EXEC.

EXEC:
- R-type (000000), addi (001000), lw (100011), sw (101011): go to WB (R-type, addi) or MEM (lw, sw).
- beq (000100): ALUOp=01. Zero is sampled at the EXEC edge; if Zero=1, pc<=pc+(signext(SEin)<<2) (mod 2^32). instr_done=1, go to FETCH.

MEM:
- lw: MemRead=1, go to WB.
- sw: MemWrite=1, instr_done=1, go to FETCH.

WB:
- RegWrite=1, instr_done=1, go to FETCH.
- MemToRegSel=1 only for lw.

Static controls:
- Regsel, ALUsel, ALUOp and MemToRegSel are decoded from IR only.
- They are stable from DECODE through the end of the instruction.
- Field outputs (rs, rt, rd, SEin, FuncCode) come directly from IR.

Per-opcode static values:
- R-type: Regsel=1, ALUsel=0, ALUOp=10.
- addi, lw, sw: ALUsel=1, ALUOp=00.
- beq: ALUsel=0, ALUOp=01.

Strobe rules:
- MemRead, MemWrite and RegWrite are each asserted for exactly one cycle per instruction, in the state listed above.

Cycle counts per instruction, with imem_ready=1:
- j: 2
- beq: 3
- sw: 4
- R-type: 4
- addi: 4
- lw: 5

Decomposition:
- Shared package (mips_ctl_pkg) holds:
  - opcode constants: OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J
  - ALUOp codes: ALUOP_ADD, ALUOP_SUB, ALUOP_FUNC
  - the 3-bit state encoding
- One natural sub-module: main_control_decoder, combinational. It maps opcode to Regsel, ALUsel, ALUOp, MemToRegSel, is_load, is_store, is_branch, is_jump and legal.
- The FSM, PC and IR live in fetch_decode_ctl.

Test Plan:
1. Reset, then fetch add (32'h0022_1820) with imem_ready=1 -> pc 0->4. Regsel=1, ALUOp=10, FuncCode=0. RegWrite pulses only in cycle 4; instr_done with it.
2. lw (32'h8C43_0008) -> ALUsel=1, ALUOp=00. MemRead only in cycle 4. RegWrite and MemToRegSel=1 in cycle 5. No MemWrite at any time.
3. beq imm=16'hFFFE at pc=8:
   - Zero=1 in EXEC -> pc=8+4-8=4.
   - Repeat with Zero=0 -> pc=12.
4. j target 26'h000_0010 from pc=32'hF000_0000 -> pc=32'hF000_0040 after 2 cycles.
5. imem_ready=0 for 3 cycles in FETCH -> pc and IR unchanged, no strobes. Then imem_ready=1 -> normal decode.
6. Assert reset in WB of lw -> RegWrite=0 in that cycle. Next cycle pc=RESET_PC, state=FETCH. Separately, opcode 6'b111111 -> illegal=1 and stays 1 until reset.

Source files
------------

// File: rtl/mips_ctl_pkg.sv
// Shared opcode, ALUOp and FSM state definitions for the multi-cycle MIPS control stage.
package mips_ctl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    // Word offset of a branch immediate, as a byte displacement.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/main_control_decoder.sv
// Combinational opcode decoder: static datapath selects and instruction class flags.
module main_control_decoder
    import mips_ctl_pkg::*;
(
    input  logic [5:0] opcode_i,
    output logic       regsel_o,
    output logic       alusel_o,
    output logic [1:0] aluop_o,
    output logic       memtoregsel_o,
    output logic       is_load_o,
    output logic       is_store_o,
    output logic       is_branch_o,
    output logic       is_jump_o,
    output logic       legal_o
);

    always_comb begin
        regsel_o      = 1'b0;
        alusel_o      = 1'b0;
        aluop_o       = ALUOP_ADD;
        memtoregsel_o = 1'b0;
        is_load_o     = 1'b0;
        is_store_o    = 1'b0;
        is_branch_o   = 1'b0;
        is_jump_o     = 1'b0;
        legal_o       = 1'b1;
        case (opcode_i)
            OP_RTYPE: begin
                regsel_o = 1'b1;
                aluop_o  = ALUOP_FUNC;
            end
            OP_ADDI: alusel_o = 1'b1;
            OP_LW: begin
                alusel_o      = 1'b1;
                memtoregsel_o = 1'b1;
                is_load_o     = 1'b1;
            end
            OP_SW: begin
                alusel_o   = 1'b1;
                is_store_o = 1'b1;
            end
            OP_BEQ: begin
                aluop_o     = ALUOP_SUB;
                is_branch_o = 1'b1;
            end
            OP_J:    is_jump_o = 1'b1;
            default: legal_o   = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_decode_ctl.sv
// Multi-cycle fetch/decode/control FSM owning PC and IR; resolves beq and j.
module fetch_decode_ctl
    import mips_ctl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        imem_ready,
    input  logic        Zero,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] SEin,
    output logic [3:0]  FuncCode,
    output logic        Regsel,
    output logic        ALUsel,
    output logic [1:0]  ALUOp,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemToRegSel,
    output logic        RegWrite,
    output logic [31:0] pc,
    output logic        instr_done,
    output logic        illegal
);

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] ir_q;
    logic        illegal_q;

    logic is_load, is_store, is_branch, is_jump, legal;

    main_control_decoder u_dec (
        .opcode_i      (ir_q[31:26]),
        .regsel_o      (Regsel),
        .alusel_o      (ALUsel),
        .aluop_o       (ALUOp),
        .memtoregsel_o (MemToRegSel),
        .is_load_o     (is_load),
        .is_store_o    (is_store),
        .is_branch_o   (is_branch),
        .is_jump_o     (is_jump),
        .legal_o       (legal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_ready) begin
                        ir_q    <= imem_data;
                        pc_q    <= pc_q + PC_INC;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (is_jump) begin
                        pc_q    <= {pc_q[31:28], ir_q[25:0], 2'b00};
                        state_q <= S_FETCH;
                    end else if (!legal) begin
                        illegal_q <= 1'b1;
                        state_q   <= S_FETCH;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_branch) begin
                        if (Zero) pc_q <= pc_q + branch_offset(ir_q[15:0]);
                        state_q <= S_FETCH;
                    end else if (is_load || is_store) begin
                        state_q <= S_MEM;
                    end else begin
                        state_q <= S_WB;
                    end
                end
                S_MEM:   state_q <= is_load ? S_WB : S_FETCH;
                S_WB:    state_q <= S_FETCH;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // Strobes follow the registered state but are forced low while reset is
    // asserted, so a reset landing in MEM/WB never commits a write.
    always_comb begin
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        instr_done = 1'b0;
        if (!reset) begin
            case (state_q)
                S_DECODE: instr_done = is_jump || !legal;
                S_EXEC:   instr_done = is_branch;
                S_MEM: begin
                    MemRead    = is_load;
                    MemWrite   = is_store;
                    instr_done = is_store;
                end
                S_WB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign illegal   = illegal_q;
    assign rs        = ir_q[25:21];
    assign rt        = ir_q[20:16];
    assign rd        = ir_q[15:11];
    assign SEin      = ir_q[15:0];
    assign FuncCode  = ir_q[3:0];

endmodule

// File: tb/tb_fetch_decode_ctl.sv
// Self-checking bench for fetch_decode_ctl against an instruction-level reference model.
module tb_fetch_decode_ctl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_data = '0;
    logic        imem_ready = 1'b0;
    logic        Zero = 1'b0;
    logic [31:0] imem_addr, pc;
    logic [4:0]  rs, rt, rd;
    logic [15:0] SEin;
    logic [3:0]  FuncCode;
    logic        Regsel, ALUsel, MemRead, MemWrite, MemToRegSel, RegWrite, instr_done, illegal;
    logic [1:0]  ALUOp;

    logic [31:0] d2 = '0;
    logic        rdy2 = 1'b0;
    logic        z2 = 1'b0;
    logic [31:0] imem_addr2, pc2;
    logic [4:0]  rs2, rt2, rd2;
    logic [15:0] SEin2;
    logic [3:0]  FuncCode2;
    logic        Regsel2, ALUsel2, MemRead2, MemWrite2, MemToRegSel2, RegWrite2, instr_done2, illegal2;
    logic [1:0]  ALUOp2;

    int unsigned npass = 0;
    int unsigned ntot  = 0;
    logic [31:0] exp_pc = '0;
    logic [31:0] last_ir = '0;
    logic        exp_illegal = 1'b0;

    always #5 clk = ~clk;

    fetch_decode_ctl #(.RESET_PC(32'h0000_0000), .PC_INC(32'd4)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
        .imem_ready(imem_ready), .Zero(Zero), .rs(rs), .rt(rt), .rd(rd), .SEin(SEin),
        .FuncCode(FuncCode), .Regsel(Regsel), .ALUsel(ALUsel), .ALUOp(ALUOp),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemToRegSel(MemToRegSel),
        .RegWrite(RegWrite), .pc(pc), .instr_done(instr_done), .illegal(illegal)
    );

    fetch_decode_ctl #(.RESET_PC(32'hF000_0000), .PC_INC(32'd4)) dut2 (
        .clk(clk), .reset(reset), .imem_addr(imem_addr2), .imem_data(d2),
        .imem_ready(rdy2), .Zero(z2), .rs(rs2), .rt(rt2), .rd(rd2), .SEin(SEin2),
        .FuncCode(FuncCode2), .Regsel(Regsel2), .ALUsel(ALUsel2), .ALUOp(ALUOp2),
        .MemRead(MemRead2), .MemWrite(MemWrite2), .MemToRegSel(MemToRegSel2),
        .RegWrite(RegWrite2), .pc(pc2), .instr_done(instr_done2), .illegal(illegal2)
    );

    // ---------------- reference model (instruction level) ----------------
    function automatic bit m_legal(input logic [5:0] op);
        return op inside {6'b000000, 6'b001000, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
    endfunction

    function automatic int m_cycles(input logic [5:0] op);
        case (op)
            6'b000010: return 2;
            6'b000100: return 3;
            6'b100011: return 5;
            6'b000000, 6'b001000, 6'b101011: return 4;
            default:   return 2;
        endcase
    endfunction

    // {Regsel, ALUsel, ALUOp, MemToRegSel}
    function automatic logic [4:0] m_static(input logic [5:0] op);
        case (op)
            6'b000000: return 5'b1_0_10_0;
            6'b001000: return 5'b0_1_00_0;
            6'b100011: return 5'b0_1_00_1;
            6'b101011: return 5'b0_1_00_0;
            6'b000100: return 5'b0_0_01_0;
            default:   return 5'b0;
        endcase
    endfunction

    // {MemRead, MemWrite, RegWrite, instr_done} expected in cycle c of the instruction
    function automatic logic [3:0] m_strobes(input logic [5:0] op, input int c);
        logic [3:0] s;
        int n;
        n = m_cycles(op);
        s = '0;
        s[3] = (op == 6'b100011) && (c == 4);
        s[2] = (op == 6'b101011) && (c == 4);
        s[1] = (op inside {6'b000000, 6'b001000, 6'b100011}) && (c == n);
        s[0] = (c == n);
        return s;
    endfunction

    function automatic logic [31:0] m_next_pc(input logic [31:0] p, input logic [31:0] ins, input logic z);
        logic [31:0] np;
        logic signed [31:0] imm;
        np  = p + 32'd4;
        imm = 32'(signed'(ins[15:0]));
        if (ins[31:26] == 6'b000010)
            np = {np[31:28], ins[25:0], 2'b00};
        else if (ins[31:26] == 6'b000100 && z)
            np = np + 32'(imm * 4);
        return np;
    endfunction

    function automatic logic [34:0] m_fields(input logic [31:0] ins);
        return {ins[25:21], ins[20:16], ins[15:11], ins[15:0], ins[3:0]};
    endfunction

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [31:0] ins, input logic z, input int stalls);
        logic [5:0]  op;
        logic [3:0]  es;
        logic [31:0] pnext;
        int n;
        op = ins[31:26];
        n  = m_cycles(op);
        for (int s = 0; s < stalls; s++) begin
            imem_ready = 1'b0;
            imem_data  = $urandom;
            ntot++;
            if ({MemRead, MemWrite, RegWrite, instr_done} !== 4'b0)
                $display("FAIL stall_strobes got %b exp 0000", {MemRead, MemWrite, RegWrite, instr_done});
            else npass++;
            ntot++;
            if (pc !== exp_pc || imem_addr !== exp_pc)
                $display("FAIL stall_pc got %h/%h exp %h", pc, imem_addr, exp_pc);
            else npass++;
            ntot++;
            if ({rs, rt, rd, SEin, FuncCode} !== m_fields(last_ir))
                $display("FAIL stall_ir got %h exp %h", {rs, rt, rd, SEin, FuncCode}, m_fields(last_ir));
            else npass++;
            step();
        end
        imem_ready = 1'b1;
        imem_data  = ins;
        Zero       = z;
        for (int c = 1; c <= n; c++) begin
            es = m_strobes(op, c);
            ntot++;
            if ({MemRead, MemWrite, RegWrite, instr_done} !== es)
                $display("FAIL strobes ins=%h cyc=%0d got %b exp %b", ins, c,
                         {MemRead, MemWrite, RegWrite, instr_done}, es);
            else npass++;
            if (c == 1) begin
                ntot++;
                if (imem_addr !== exp_pc || pc !== exp_pc)
                    $display("FAIL fetch_addr ins=%h got %h exp %h", ins, imem_addr, exp_pc);
                else npass++;
            end else begin
                ntot++;
                if (pc !== exp_pc + 32'd4)
                    $display("FAIL pc_mid ins=%h cyc=%0d got %h exp %h", ins, c, pc, exp_pc + 32'd4);
                else npass++;
                ntot++;
                if ({rs, rt, rd, SEin, FuncCode} !== m_fields(ins))
                    $display("FAIL fields ins=%h got %h exp %h", ins, {rs, rt, rd, SEin, FuncCode}, m_fields(ins));
                else npass++;
                if (m_legal(op) && op != 6'b000010) begin
                    ntot++;
                    if ({Regsel, ALUsel, ALUOp, MemToRegSel} !== m_static(op))
                        $display("FAIL statics ins=%h cyc=%0d got %b exp %b", ins, c,
                                 {Regsel, ALUsel, ALUOp, MemToRegSel}, m_static(op));
                    else npass++;
                end
            end
            step();
            imem_ready = 1'b0;
        end
        pnext = m_next_pc(exp_pc, ins, z);
        exp_pc  = pnext;
        last_ir = ins;
        if (!m_legal(op)) exp_illegal = 1'b1;
        ntot++;
        if (pc !== exp_pc) $display("FAIL next_pc ins=%h z=%b got %h exp %h", ins, z, pc, exp_pc);
        else npass++;
        ntot++;
        if (illegal !== exp_illegal) $display("FAIL illegal ins=%h got %b exp %b", ins, illegal, exp_illegal);
        else npass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) step();
        ntot++;
        if (pc !== 32'h0 || imem_addr !== 32'h0) $display("FAIL reset_pc got %h exp 00000000", pc);
        else npass++;
        ntot++;
        if ({MemRead, MemWrite, RegWrite, instr_done, illegal} !== 5'b0)
            $display("FAIL reset_strobes got %b exp 00000", {MemRead, MemWrite, RegWrite, instr_done, illegal});
        else npass++;
        ntot++;
        if (pc2 !== 32'hF000_0000) $display("FAIL reset_pc2 got %h exp f0000000", pc2);
        else npass++;
        reset = 1'b0;
        exp_pc = '0; last_ir = '0; exp_illegal = 1'b0;
    endtask

    task automatic test_rtype();
        run_instr(32'h0022_1820, 1'b0, 0);
    endtask

    task automatic test_lw();
        run_instr(32'h8C43_0008, 1'b0, 0);
    endtask

    task automatic test_beq();
        run_instr({6'b000100, 5'd1, 5'd2, 16'hFFFE}, 1'b1, 0);
        ntot++;
        if (pc !== 32'd4) $display("FAIL beq_taken got %h exp 00000004", pc);
        else npass++;
        run_instr(32'h0022_1820, 1'b0, 0);
        run_instr({6'b000100, 5'd1, 5'd2, 16'hFFFE}, 1'b0, 0);
        ntot++;
        if (pc !== 32'd12) $display("FAIL beq_not_taken got %h exp 0000000c", pc);
        else npass++;
    endtask

    task automatic test_stall();
        run_instr({6'b101011, 5'd4, 5'd5, 16'h0010}, 1'b0, 3);
        run_instr({6'b001000, 5'd6, 5'd7, 16'h8001}, 1'b0, 2);
    endtask

    task automatic test_illegal();
        run_instr({6'b111111, 26'h3FF_FFFF}, 1'b0, 0);
        run_instr(32'h0022_1820, 1'b0, 1);
        ntot++;
        if (illegal !== 1'b1) $display("FAIL illegal_sticky got %b exp 1", illegal);
        else npass++;
    endtask

    task automatic test_random();
        logic [5:0]  ops [6];
        logic [5:0]  op;
        logic [31:0] r;
        ops = '{6'b000000, 6'b001000, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
        for (int i = 0; i < 60; i++) begin
            r = $urandom;
            if ($urandom_range(0, 9) == 0) begin
                op = 6'($urandom);
                while (m_legal(op)) op = 6'($urandom);
            end else begin
                op = ops[$urandom_range(0, 5)];
            end
            run_instr({op, r[25:0]}, 1'($urandom), int'($urandom_range(0, 2)));
        end
    endtask

    task automatic test_reset_in_wb();
        imem_ready = 1'b1;
        imem_data  = 32'h8C43_0008;
        for (int c = 1; c <= 4; c++) begin
            step();
            imem_ready = 1'b0;
        end
        ntot++;
        if (RegWrite !== 1'b1) $display("FAIL wb_reach got %b exp 1", RegWrite);
        else npass++;
        reset = 1'b1;
        #1;
        ntot++;
        if ({RegWrite, instr_done, MemRead, MemWrite} !== 4'b0)
            $display("FAIL reset_gate got %b exp 0000", {RegWrite, instr_done, MemRead, MemWrite});
        else npass++;
        step();
        reset = 1'b0;
        ntot++;
        if (pc !== 32'h0 || illegal !== 1'b0) $display("FAIL reset_wb_pc got %h/%b exp 00000000/0", pc, illegal);
        else npass++;
        exp_pc = '0; last_ir = '0; exp_illegal = 1'b0;
        run_instr(32'h0022_1820, 1'b0, 1);
    endtask

    task automatic test_jump();
        rdy2 = 1'b1;
        d2   = {6'b000010, 26'h000_0010};
        ntot++;
        if (imem_addr2 !== 32'hF000_0000) $display("FAIL j_fetch got %h exp f0000000", imem_addr2);
        else npass++;
        step();
        rdy2 = 1'b0;
        ntot++;
        if (instr_done2 !== 1'b1 || pc2 !== 32'hF000_0004)
            $display("FAIL j_decode got %b/%h exp 1/f0000004", instr_done2, pc2);
        else npass++;
        step();
        ntot++;
        if (pc2 !== 32'hF000_0040 || instr_done2 !== 1'b0)
            $display("FAIL j_target got %h/%b exp f0000040/0", pc2, instr_done2);
        else npass++;
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw();
        test_beq();
        test_stall();
        test_jump();
        test_illegal();
        test_random();
        test_reset_in_wb();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
